// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA timing generator:
//   - default 640x480@60 timing constants
//   - the four-segment state type used by both axis sequencers
//   - the axis total / next-segment helpers
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Position and segment counters are 10 bits wide, so one axis can span
  // at most 1024 positions.
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_H_FRONT     = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BACK      = 48;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_V_FRONT     = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BACK      = 33;

  typedef enum logic [1:0] {
    SEG_ACTIVE = 2'd0,
    SEG_FRONT  = 2'd1,
    SEG_SYNC   = 2'd2,
    SEG_BACK   = 2'd3
  } seg_state_e;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic seg_state_e seg_next(input seg_state_e s);
    seg_state_e n;
    case (s)
      SEG_ACTIVE: n = SEG_FRONT;
      SEG_FRONT:  n = SEG_SYNC;
      SEG_SYNC:   n = SEG_BACK;
      default:    n = SEG_ACTIVE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// -----------------------------------------------------------------------------
// vga_axis_seq
// One timing axis: a four-segment FSM, each segment timed by a down-counter
// with terminal-count compare, plus the position counter along the axis.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   SEG_ACTIVE | visible region, LEN_ACTIVE positions
//   SEG_FRONT  | front porch, LEN_FRONT positions
//   SEG_SYNC   | sync pulse, LEN_SYNC positions
//   SEG_BACK   | back porch, LEN_BACK positions; last one wraps
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   clear_i     force back to position 0 / SEG_ACTIVE on the next edge
//   advance_i   step one position on the next edge
//   pos_o       registered position, 0..total-1
//   state_d_o   next segment state (lets the parent register combined flags)
//   sync_o      registered sync level for the current position
//   wrap_o      this edge moves the last position back to 0
// -----------------------------------------------------------------------------
module vga_axis_seq
  import vga_timing_pkg::*;
#(
  parameter int LEN_ACTIVE = DEF_ACTIVE_COLS,
  parameter int LEN_FRONT  = DEF_H_FRONT,
  parameter int LEN_SYNC   = DEF_H_SYNC,
  parameter int LEN_BACK   = DEF_H_BACK,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [CNT_W-1:0] pos_o,
  output seg_state_e       state_d_o,
  output logic             sync_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(LEN_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(LEN_FRONT - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(LEN_SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_BACK   = CNT_W'(LEN_BACK - 1);

  function automatic logic [CNT_W-1:0] seg_last(input seg_state_e s);
    logic [CNT_W-1:0] v;
    case (s)
      SEG_ACTIVE: v = LAST_ACTIVE;
      SEG_FRONT:  v = LAST_FRONT;
      SEG_SYNC:   v = LAST_SYNC;
      default:    v = LAST_BACK;
    endcase
    return v;
  endfunction

  seg_state_e       state_q, state_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             sync_q, sync_d;
  logic             wrap;

  always_comb begin
    state_d   = state_q;
    seg_cnt_d = seg_cnt_q;
    pos_d     = pos_q;
    wrap      = 1'b0;
    if (clear_i) begin
      state_d   = SEG_ACTIVE;
      seg_cnt_d = LAST_ACTIVE;
      pos_d     = '0;
    end else if (advance_i) begin
      if (seg_cnt_q == '0) begin
        state_d   = seg_next(state_q);
        seg_cnt_d = seg_last(seg_next(state_q));
        if (state_q == SEG_BACK) begin
          wrap  = 1'b1;
          pos_d = '0;
        end else begin
          pos_d = pos_q + CNT_W'(1);
        end
      end else begin
        seg_cnt_d = seg_cnt_q - CNT_W'(1);
        pos_d     = pos_q + CNT_W'(1);
      end
    end
    // Sync level is registered from the next state so it lines up with pos_q.
    sync_d = (state_d == SEG_SYNC) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SEG_ACTIVE;
      seg_cnt_q <= LAST_ACTIVE;
      pos_q     <= '0;
      sync_q    <= ~SYNC_POL;
    end else begin
      state_q   <= state_d;
      seg_cnt_q <= seg_cnt_d;
      pos_q     <= pos_d;
      sync_q    <= sync_d;
    end
  end

  assign pos_o     = pos_q;
  assign state_d_o = state_d;
  assign sync_o    = sync_q;
  assign wrap_o    = wrap;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Source-side VGA timing generator. A horizontal axis sequencer steps every
// enabled clock; a vertical one steps on each horizontal wrap. All outputs are
// registered and describe the column/row presented in the same cycle.
//
// Optional build macro: VGA_SYNC_GEN_PATTERN_EN
//   defined   - RGB outputs show 8 vertical colour bars in the active area
//   undefined - RGB outputs are tied to 0
//
// Ports:
//   i_Clk          pixel clock
//   i_Rst_L        asynchronous active-low reset
//   i_Enable       run timing; low holds the block in idle blanking
//   o_HSync        horizontal sync (asserted level = SYNC_POL)
//   o_VSync        vertical sync (asserted level = SYNC_POL)
//   o_Active       visible pixel
//   o_Col_Count    current column
//   o_Row_Count    current row
//   o_Frame_Start  one-cycle pulse at col 0 / row 0
//   o_Red_Video, o_Grn_Video, o_Blu_Video   pattern output
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter bit SYNC_POL    = 1'b0,
  parameter int VIDEO_WIDTH = 3
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Enable,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_Active,
  output logic [CNT_W-1:0]       o_Col_Count,
  output logic [CNT_W-1:0]       o_Row_Count,
  output logic                   o_Frame_Start,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

  localparam int TOTAL_COLS = axis_total(ACTIVE_COLS, H_FRONT, H_SYNC, H_BACK);
  localparam int TOTAL_ROWS = axis_total(ACTIVE_ROWS, V_FRONT, V_SYNC, V_BACK);

  if (TOTAL_COLS > CNT_MAX) begin : g_err_cols
    $error("vga_sync_gen: TOTAL_COLS exceeds the 10-bit counter range");
  end
  if (TOTAL_ROWS > CNT_MAX) begin : g_err_rows
    $error("vga_sync_gen: TOTAL_ROWS exceeds the 10-bit counter range");
  end
  if (ACTIVE_COLS < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_err_hseg
    $error("vga_sync_gen: horizontal segments must be at least one clock long");
  end
  if (ACTIVE_ROWS < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_err_vseg
    $error("vga_sync_gen: vertical segments must be at least one line long");
  end
  if (VIDEO_WIDTH < 1) begin : g_err_vw
    $error("vga_sync_gen: VIDEO_WIDTH must be at least 1");
  end

  // run_q is low while idle; the first enabled edge after idle re-presents
  // position 0/0 (with the frame-start pulse) instead of advancing.
  logic       run_q;
  logic       active_q, active_d;
  logic       frame_start_q, frame_start_d;
  logic       axis_clear, h_adv;
  logic       h_wrap, v_wrap;
  seg_state_e h_state_d, v_state_d;

  always_comb begin
    axis_clear    = ~i_Enable;
    h_adv         = i_Enable & run_q;
    active_d      = i_Enable && (h_state_d == SEG_ACTIVE) && (v_state_d == SEG_ACTIVE);
    frame_start_d = i_Enable && (!run_q || v_wrap);
  end

  vga_axis_seq #(
    .LEN_ACTIVE (ACTIVE_COLS),
    .LEN_FRONT  (H_FRONT),
    .LEN_SYNC   (H_SYNC),
    .LEN_BACK   (H_BACK),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .clk_i     (i_Clk),
    .rst_ni    (i_Rst_L),
    .clear_i   (axis_clear),
    .advance_i (h_adv),
    .pos_o     (o_Col_Count),
    .state_d_o (h_state_d),
    .sync_o    (o_HSync),
    .wrap_o    (h_wrap)
  );

  // Row steps only on the line-wrap edge, so VSync edges land on col 0.
  vga_axis_seq #(
    .LEN_ACTIVE (ACTIVE_ROWS),
    .LEN_FRONT  (V_FRONT),
    .LEN_SYNC   (V_SYNC),
    .LEN_BACK   (V_BACK),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .clk_i     (i_Clk),
    .rst_ni    (i_Rst_L),
    .clear_i   (axis_clear),
    .advance_i (h_wrap),
    .pos_o     (o_Row_Count),
    .state_d_o (v_state_d),
    .sync_o    (o_VSync),
    .wrap_o    (v_wrap)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      run_q         <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= i_Enable;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_Active      = active_q;
  assign o_Frame_Start = frame_start_q;

`ifdef VGA_SYNC_GEN_PATTERN_EN
  localparam int BAR_W = ACTIVE_COLS / 8;

  if (BAR_W < 1) begin : g_err_bar
    $error("vga_sync_gen: ACTIVE_COLS too small for an 8-bar pattern");
  end

  logic [CNT_W-1:0]       pat_col_d;
  logic [CNT_W-1:0]       bar_full_d;
  logic [2:0]             bar_d;
  logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;
  logic [VIDEO_WIDTH-1:0] red_d, grn_d, blu_d;

  always_comb begin
    // Column that the counters will present after this edge.
    pat_col_d = '0;
    if (h_adv && !h_wrap) begin
      pat_col_d = o_Col_Count + CNT_W'(1);
    end
    bar_full_d = pat_col_d / CNT_W'(BAR_W);
    bar_d      = bar_full_d[2:0];
    red_d      = (active_d && bar_d[2]) ? '1 : '0;
    grn_d      = (active_d && bar_d[1]) ? '1 : '0;
    blu_d      = (active_d && bar_d[0]) ? '1 : '0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
    end else begin
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
    end
  end

  assign o_Red_Video = red_q;
  assign o_Grn_Video = grn_q;
  assign o_Blu_Video = blu_q;
`else
  assign o_Red_Video = '0;
  assign o_Grn_Video = '0;
  assign o_Blu_Video = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Self-checking bench for vga_sync_gen using a reduced timing (80 x 31) so
// several whole frames fit in a short run. The reference keeps only a running
// pixel index since the last start; column/row and every output are derived
// from it arithmetically.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int AC = 64, HF = 4, HS = 8, HB = 4;
  localparam int AR = 24, VF = 2, VS = 2, VB = 3;
  localparam int VW = 3;
  localparam int TC = AC + HF + HS + HB;  // 80
  localparam int TR = AR + VF + VS + VB;  // 31

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          hs, vs, act, fs;
  logic [9:0]    col, row;
  logic [VW-1:0] red, grn, blu;

  vga_sync_gen #(
    .ACTIVE_COLS (AC), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .ACTIVE_ROWS (AR), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SYNC_POL (1'b0), .VIDEO_WIDTH (VW)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Enable      (en),
    .o_HSync       (hs),
    .o_VSync       (vs),
    .o_Active      (act),
    .o_Col_Count   (col),
    .o_Row_Count   (row),
    .o_Frame_Start (fs),
    .o_Red_Video   (red),
    .o_Grn_Video   (grn),
    .o_Blu_Video   (blu)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: m_run says the timing is running, m_t counts pixels since the
  // cycle that presented col 0 / row 0.
  bit m_run = 1'b0;
  int m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      m_t   <= 0;
    end else if (!en) begin
      m_run <= 1'b0;
      m_t   <= 0;
    end else if (!m_run) begin
      m_run <= 1'b1;
      m_t   <= 0;
    end else begin
      m_t   <= (m_t + 1) % (TC * TR);
    end
  end

  function automatic int m_col();
    return m_run ? (m_t % TC) : 0;
  endfunction

  function automatic int m_row();
    return m_run ? ((m_t / TC) % TR) : 0;
  endfunction

  always @(negedge clk) begin : cmp
    int c, r, ehs, evs, eact, efs, er, eg, eb, bar;
    c = m_col();
    r = m_row();
    ehs = 1; evs = 1; eact = 0; efs = 0; er = 0; eg = 0; eb = 0;
    if (m_run) begin
      ehs  = (c >= AC + HF && c < AC + HF + HS) ? 0 : 1;
      evs  = (r >= AR + VF && r < AR + VF + VS) ? 0 : 1;
      eact = (c < AC && r < AR) ? 1 : 0;
      efs  = (c == 0 && r == 0) ? 1 : 0;
`ifdef VGA_SYNC_GEN_PATTERN_EN
      bar = c / (AC / 8);
      if (eact == 1) begin
        er = ((bar >> 2) & 1) * ((1 << VW) - 1);
        eg = ((bar >> 1) & 1) * ((1 << VW) - 1);
        eb = (bar & 1) * ((1 << VW) - 1);
      end
`endif
    end
    check("col",    col, c);
    check("row",    row, r);
    check("hsync",  hs,  ehs);
    check("vsync",  vs,  evs);
    check("active", act, eact);
    check("fstart", fs,  efs);
    check("red",    red, er);
    check("grn",    grn, eg);
    check("blu",    blu, eb);
  end

  task automatic wait_pos(input int c, input int r, input int budget);
    int n;
    n = 0;
    while (!(m_run && m_col() == c && m_row() == r) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_in_budget", (n < budget) ? 1 : 0, 1);
  endtask

  initial begin : stim
    int hs_low, act_cnt, vs_low, k, d;
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_col", col, 0);
    check("reset_hs",  hs,  1);
    check("reset_fs",  fs,  0);
    check("reset_act", act, 0);
    rst_n = 1'b1;

    // First enabled cycle presents col 0 / row 0 with the frame pulse.
    @(negedge clk);
    check("first_fs",  fs,  1);
    check("first_act", act, 1);
    check("first_col", col, 0);

    // One line: HSync low for cols 68..75, active for cols 0..63.
    hs_low = 0; act_cnt = 0;
    for (int i = 0; i < TC; i++) begin
      if (hs == 1'b0) hs_low++;
      if (act == 1'b1) act_cnt++;
      if (i == TC - 1) check("last_col", col, TC - 1);
      if (i < TC - 1) @(negedge clk);
    end
    check("hs_width", hs_low, 8);
    check("act_width", act_cnt, 64);
    @(negedge clk);
    check("col_wrap", col, 0);
    check("row_step", row, 1);

    // Rest of the frame: next pulse exactly TC*TR clocks after the first.
    k = TC; vs_low = 0;
    while (k < 4 * TC * TR) begin
      if (vs == 1'b0) vs_low++;
      @(negedge clk);
      k++;
      if (fs == 1'b1) break;
    end
    check("frame_period", k, 2480);
    check("vs_width", vs_low, 160);

    // Disable mid-frame for 5 clocks, then re-enable.
    wait_pos(30, 10, 3000);
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("dis_hs",  hs,  1);
      check("dis_act", act, 0);
    end
    en = 1'b1;
    @(negedge clk);
    check("reen_col", col, 0);
    check("reen_row", row, 0);
    check("reen_fs",  fs,  1);

    // Asynchronous reset in the middle of an HSync pulse.
    wait_pos(70, 3, 3000);
    check("mid_hsync", hs, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hs",  hs,  1);
    check("arst_col", col, 0);
    check("arst_row", row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_fs", fs, 1);

`ifdef VGA_SYNC_GEN_PATTERN_EN
    wait_pos(0, 1, 3000);
    check("pat_c0", {red, grn, blu}, {3'd0, 3'd0, 3'd0});
    wait_pos(8, 1, 3000);
    check("pat_c8", {red, grn, blu}, {3'd0, 3'd0, 3'd7});
    wait_pos(56, 1, 3000);
    check("pat_c56", {red, grn, blu}, {3'd7, 3'd7, 3'd7});
    wait_pos(70, 1, 3000);
    check("pat_c70", {red, grn, blu}, {3'd0, 3'd0, 3'd0});
`endif

    // Random runs interrupted by disables, short glitches and async resets.
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(50, 3000)) @(negedge clk);
      case ($urandom_range(0, 2))
        0: begin
          en = 1'b0;
          repeat ($urandom_range(1, 10)) @(negedge clk);
          en = 1'b1;
        end
        1: begin
          d = $urandom_range(1, 4);
          if ($urandom_range(0, 1) == 1) d += 5;
          #(d) rst_n = 1'b0;
          @(negedge clk);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          rst_n = 1'b1;
        end
        default: begin
          en = 1'b0;
          @(negedge clk);
          en = 1'b1;
        end
      endcase
    end
    repeat (200) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
